mod_unit_32bit: RTL and testbench

Sequential unsigned modulo unit that produces the op_mod operand for the ALU result selector (select code 3'b111).
- Computes op_a mod op_b with a restoring shift-subtract loop, one quotient bit per clock.
- Uses a start/busy/done handshake so the ALU controller can wait for the result before selecting it.
- Holds the result stable between operations so the selector sees a steady op_mod.

---
 rtl/mod_unit_32bit_if.sv | 22 ++
 rtl/mod_unit_32bit.sv | 100 ++++++++++
 tb/tb_mod_unit_32bit.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/mod_unit_32bit_if.sv
// Handshake and operand bus between the ALU controller and the modulo unit.
interface mod_unit_32bit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] op_mod;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, op_a, op_b,
    input  op_mod, busy, done, div_by_zero
  );

  modport slave (
    input  start, op_a, op_b,
    output op_mod, busy, done, div_by_zero
  );
endinterface

// File: rtl/mod_unit_32bit.sv
// Sequential unsigned modulo (restoring shift-subtract, one bit per clock).
// Produces op_mod for the ALU result selector and holds it between operations.
module mod_unit_32bit #(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  mod_unit_32bit_if.slave   bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] mod_q, mod_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             fits;
  logic             lastStep;
  logic             accept;
  logic             zeroDiv;

  // The shifted value carries one extra bit so a divisor above 2^(WIDTH-1)
  // cannot overflow; after subtraction the remainder always fits in WIDTH bits.
  assign shifted  = {rem_q, dvd_q[WIDTH-1]};
  assign fits     = shifted >= {1'b0, dvs_q};
  assign trial    = fits ? (shifted - {1'b0, dvs_q}) : shifted;
  assign lastStep = (cnt_q == CNT_W'(WIDTH - 1));
  assign zeroDiv  = (bus.op_b == '0);
  assign accept   = (state_q == IDLE) && bus.start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      mod_q   <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      mod_q   <= mod_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = zeroDiv ? DONE : CALC;
      CALC:    if (lastStep) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rem_d = rem_q;
    dvd_d = dvd_q;
    dvs_d = dvs_q;
    mod_d = mod_q;
    cnt_d = cnt_q;
    dbz_d = dbz_q;
    if (accept) begin
      if (zeroDiv) begin
        mod_d = bus.op_a;
        dbz_d = 1'b1;
      end else begin
        dvd_d = bus.op_a;
        dvs_d = bus.op_b;
        rem_d = '0;
        cnt_d = '0;
        dbz_d = 1'b0;
      end
    end else if (state_q == CALC) begin
      rem_d = trial[WIDTH-1:0];
      dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
      cnt_d = cnt_q + 1'b1;
      if (lastStep) mod_d = trial[WIDTH-1:0];
    end
  end

  always_comb begin
    bus.busy        = (state_q == CALC);
    bus.done        = (state_q == DONE);
    bus.op_mod      = mod_q;
    bus.div_by_zero = dbz_q;
  end
endmodule

// File: tb/tb_mod_unit_32bit.sv
// Randomized self-checking bench for mod_unit_32bit against a plain-arithmetic model.
module tb_mod_unit_32bit;
  logic clk;
  logic rst_n;
  int   checkCount;
  int   passCount;

  mod_unit_32bit_if #(.WIDTH(32)) bus ();

  mod_unit_32bit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
  endtask

  // One full operation; injectAt >= 0 drives a stray start that must be ignored.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input int injectAt);
    logic [31:0] expMod;
    logic        expDbz;
    int          expLat, cyc, busyCyc;
    logic        overlap;
    expDbz  = (b == 32'd0);
    expMod  = expDbz ? a : (a % b);
    expLat  = expDbz ? 0 : 32;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op_a  = a;
    bus.op_b  = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op_a  = $urandom;
    bus.op_b  = $urandom;
    cyc     = 0;
    busyCyc = 0;
    overlap = 1'b0;
    while (!bus.done && cyc < 200) begin
      if (bus.busy) busyCyc++;
      if (cyc == injectAt) begin
        bus.start = 1'b1;
        bus.op_a  = 32'd9;
        bus.op_b  = 32'd2;
      end else if (cyc == injectAt + 3) begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (bus.busy && bus.done) overlap = 1'b1;
    end
    bus.start = 1'b0;
    checkOutput("latency", 32'(cyc), 32'(expLat));
    checkOutput("busyCycles", 32'(busyCyc), 32'(expLat));
    checkOutput("busyDoneOverlap", {31'd0, overlap}, 32'd0);
    checkOutput("opMod", bus.op_mod, expMod);
    checkOutput("divByZero", {31'd0, bus.div_by_zero}, {31'd0, expDbz});
    // A start presented during DONE must not launch a new operation.
    bus.start = 1'b1;
    bus.op_a  = $urandom;
    bus.op_b  = 32'd1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    checkOutput("donePulseEnds", {31'd0, bus.done}, 32'd0);
    checkOutput("startInDoneIgnored", {31'd0, bus.busy}, 32'd0);
    checkOutput("opModHeld", bus.op_mod, expMod);
  endtask

  initial begin
    logic [31:0] a, b;
    int          mode;
    checkCount = 0;
    passCount  = 0;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.op_a   = '0;
    bus.op_b   = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetOpMod", bus.op_mod, 32'd0);
    checkOutput("resetBusy", {31'd0, bus.busy}, 32'd0);
    checkOutput("resetDone", {31'd0, bus.done}, 32'd0);
    checkOutput("resetDbz", {31'd0, bus.div_by_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(32'd100, 32'd7, -1);
    applyStimulus(32'd5, 32'd9, -1);
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    applyStimulus(32'hFFFF_FFFF, 32'h8000_0001, -1);
    applyStimulus(32'd0, 32'd17, -1);
    applyStimulus(32'd1234, 32'd0, -1);

    // Asynchronous reset mid-operation: outputs clear at once, no done pulse.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op_a  = 32'd77;
    bus.op_b  = 32'd5;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("abortOpMod", bus.op_mod, 32'd0);
    checkOutput("abortBusy", {31'd0, bus.busy}, 32'd0);
    checkOutput("abortDone", {31'd0, bus.done}, 32'd0);
    checkOutput("abortDbz", {31'd0, bus.div_by_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      checkOutput("idleAfterAbort", {30'd0, bus.busy, bus.done}, 32'd0);
    end
    applyStimulus(32'd77, 32'd5, -1);

    applyStimulus(32'd10, 32'd3, -1);
    applyStimulus(32'd1000, 32'd13, 5);

    for (int i = 0; i < 16; i++) begin
      a    = $urandom;
      mode = $urandom_range(0, 5);
      case (mode)
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 16);
        2:       b = $urandom | 32'h8000_0000;
        3:       b = a;
        4:       begin a = $urandom_range(0, 1000); b = $urandom; end
        default: b = $urandom;
      endcase
      applyStimulus(a, b, (i % 3 == 0) ? $urandom_range(0, 25) : -1);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
